// File: rtl/selector_pkg.sv
// Shared definitions for the LFSR tap collector: tap byte width and FSM state encoding.
package selector_pkg;

    localparam int TAP_BYTE_W = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FINISH  = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/tap_dup_check.sv
// Combinational duplicate detector: hit when the candidate equals any valid slot.
// Zero latency; no flow control.
module tap_dup_check
    import selector_pkg::*;
#(
    parameter int NUM_OF_TAPS = 15
) (
    input  logic [TAP_BYTE_W-1:0]             i_cand,
    input  logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] i_slots,
    input  logic [NUM_OF_TAPS-1:0]            i_valid,
    output logic                              o_hit
);

    // Empty slots hold zero, so the valid bit must gate every comparison.
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < NUM_OF_TAPS; i++) begin
            if (i_valid[i] && (i_slots[i*TAP_BYTE_W +: TAP_BYTE_W] == i_cand)) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_tap_collector.sv
// Collects NUM_OF_TAPS distinct LFSR taps (1..SIZE-1) from random candidates; one take per enabled cycle.
// Optional FORCE_MAX_TAP_EN guarantees tap SIZE-1 is present by overwriting slot 0 on completion.
module lfsr_tap_collector
    import selector_pkg::*;
#(
    parameter int NUM_OF_TAPS = 15,
    parameter int SIZE        = 32,
    parameter int DIN_W       = 8
) (
    input  logic                                clk,
    input  logic                                res,
    input  logic                                clr,
    input  logic                                ena,
    input  logic                                take,
    input  logic [DIN_W-1:0]                    din,
    output logic [NUM_OF_TAPS*TAP_BYTE_W-1:0]   taps,
    output logic [$clog2(NUM_OF_TAPS+1)-1:0]    count,
    output logic                                rejected,
    output logic                                done
);

    localparam int TW = $clog2(SIZE);
    localparam int CW = $clog2(NUM_OF_TAPS+1);

    if ((NUM_OF_TAPS < 1) || (NUM_OF_TAPS > SIZE-1)) begin : g_bad_cfg
        $error("lfsr_tap_collector: NUM_OF_TAPS must be in 1..SIZE-1");
    end

    logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] r_taps;
    logic [NUM_OF_TAPS-1:0]            r_valid;
    logic [CW-1:0]                     r_count;
    logic                              r_done;
    logic                              r_rejected;
    state_t                            r_state;

    logic [TW-1:0]         w_cand;
    logic [TAP_BYTE_W-1:0] w_cand_byte;
    logic                  w_in_range;
    logic                  w_dup_hit;
    logic                  w_accept;
    logic                  w_unused_din;

    assign w_cand       = din[TW-1:0];
    assign w_cand_byte  = TAP_BYTE_W'(w_cand);
    assign w_in_range   = {1'b0, w_cand} < (TW+1)'(SIZE);
    assign w_accept     = (w_cand != '0) && w_in_range && !w_dup_hit;
    assign w_unused_din = ^din;

    tap_dup_check #(.NUM_OF_TAPS(NUM_OF_TAPS)) u_dup (
        .i_cand  (w_cand_byte),
        .i_slots (r_taps),
        .i_valid (r_valid),
        .o_hit   (w_dup_hit)
    );

`ifdef FORCE_MAX_TAP_EN
    localparam logic [TAP_BYTE_W-1:0] MAX_TAP = TAP_BYTE_W'(SIZE-1);
    logic w_max_hit;

    tap_dup_check #(.NUM_OF_TAPS(NUM_OF_TAPS)) u_max (
        .i_cand  (MAX_TAP),
        .i_slots (r_taps),
        .i_valid (r_valid),
        .o_hit   (w_max_hit)
    );
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_taps     <= '0;
            r_valid    <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_rejected <= 1'b0;
            r_state    <= COLLECT;
        end else begin
            // rejected is a pulse, so it drops even while ena freezes the rest
            r_rejected <= 1'b0;
            if (ena) begin
                if (clr) begin
                    r_taps  <= '0;
                    r_valid <= '0;
                    r_count <= '0;
                    r_done  <= 1'b0;
                    r_state <= COLLECT;
                end else begin
                    case (r_state)
                        COLLECT: begin
                            if (take) begin
                                if (w_accept) begin
                                    for (int i = 0; i < NUM_OF_TAPS; i++) begin
                                        if (r_count == CW'(i)) begin
                                            r_taps[i*TAP_BYTE_W +: TAP_BYTE_W] <= w_cand_byte;
                                            r_valid[i] <= 1'b1;
                                        end
                                    end
                                    r_count <= r_count + 1'b1;
                                    if (r_count == CW'(NUM_OF_TAPS-1)) begin
                                        r_state <= FINISH;
                                    end
                                end else begin
                                    r_rejected <= 1'b1;
                                end
                            end
                        end
                        FINISH: begin
`ifdef FORCE_MAX_TAP_EN
                            if (!w_max_hit) begin
                                r_taps[TAP_BYTE_W-1:0] <= MAX_TAP;
                            end
`endif
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                        DONE: begin
                            r_state <= DONE;
                        end
                        default: begin
                            r_state <= COLLECT;
                        end
                    endcase
                end
            end
        end
    end

    assign taps     = r_taps;
    assign count    = r_count;
    assign rejected = r_rejected;
    assign done     = r_done;

endmodule

// File: tb/tb_lfsr_tap_collector.sv
// Directed bench for lfsr_tap_collector (NUM_OF_TAPS=4, SIZE=32, DIN_W=8); honours FORCE_MAX_TAP_EN.
module tb_lfsr_tap_collector;

    localparam int NT = 4;
    localparam int SZ = 32;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        clr = 1'b0;
    logic        ena = 1'b0;
    logic        take = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [31:0] taps;
    logic [2:0]  count;
    logic        rejected;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Model: list of accepted tap values plus a phase (0 collecting, 1 finishing, 2 complete).
    int m_vals[$];
    int m_phase = 0;
    bit m_rej = 1'b0;

    lfsr_tap_collector #(.NUM_OF_TAPS(NT), .SIZE(SZ), .DIN_W(8)) dut (
        .clk      (clk),
        .res      (res),
        .clr      (clr),
        .ena      (ena),
        .take     (take),
        .din      (din),
        .taps     (taps),
        .count    (count),
        .rejected (rejected),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_taps();
        logic [31:0] t = '0;
        for (int i = 0; i < m_vals.size(); i++) t[i*8 +: 8] = 8'(m_vals[i]);
        return t;
    endfunction

    function automatic void model_clear();
        m_vals.delete();
        m_phase = 0;
        m_rej   = 1'b0;
    endfunction

    function automatic void model_edge();
        int  c;
        bit  seen;
        m_rej = 1'b0;
        if (!ena) return;
        if (clr) begin
            m_vals.delete();
            m_phase = 0;
            return;
        end
        if (m_phase == 0) begin
            if (take) begin
                c = int'(din) % SZ;
                seen = 1'b0;
                foreach (m_vals[i]) if (m_vals[i] == c) seen = 1'b1;
                if (c != 0 && !seen) begin
                    m_vals.push_back(c);
                    if (m_vals.size() == NT) m_phase = 1;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
`ifdef FORCE_MAX_TAP_EN
            seen = 1'b0;
            foreach (m_vals[i]) if (m_vals[i] == SZ-1) seen = 1'b1;
            if (!seen) m_vals[0] = SZ-1;
`endif
            m_phase = 2;
        end
    endfunction

    task automatic compare_all();
        chk("taps",     taps,               model_taps());
        chk("count",    32'(count),         32'(m_vals.size()));
        chk("rejected", 32'(rejected),      32'(m_rej));
        chk("done",     32'(done),          32'(m_phase == 2));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare after the edge.
    task automatic step(input logic c, input logic e, input logic t, input logic [7:0] d);
        clr = c; ena = e; take = t; din = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic take_one(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic restart();
        step(1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #12;
        model_clear();
        compare_all();
        chk("reset_taps", taps, 32'h0);
        res = 1'b0;
        @(negedge clk);

        // Four distinct accepts, done one edge after the last
        take_one(8'h05); take_one(8'h03); take_one(8'h1F); take_one(8'h02);
        chk("t1_count_at_last", 32'(count), 32'd4);
        chk("t1_done_not_yet", 32'(done), 32'd0);
        idle();
        chk("t1_taps", taps, 32'h021F0305);
        chk("t1_done", 32'(done), 32'd1);
        take_one(8'h0A); take_one(8'h11);
        chk("done_hold_taps", taps, 32'h021F0305);
        restart();

        // Zero, aliased duplicate and plain duplicate are rejected
        take_one(8'h00);
        chk("t2_rej_zero", 32'(rejected), 32'd1);
        take_one(8'h05); take_one(8'h25);
        chk("t2_rej_alias", 32'(rejected), 32'd1);
        take_one(8'h05); take_one(8'h07);
        chk("t2_slots", 32'(taps[15:0]), 32'h0705);
        chk("t2_count", 32'(count), 32'd2);
        restart();

        // Max tap forcing
        take_one(8'h04); take_one(8'h06); take_one(8'h08); take_one(8'h09);
        idle();
`ifdef FORCE_MAX_TAP_EN
        chk("t3_taps", taps, 32'h0908061F);
`else
        chk("t3_taps", taps, 32'h09080604);
`endif
        restart();

        // Async reset mid-collection
        take_one(8'h01); take_one(8'h02);
        #2 res = 1'b1;
        #1;
        model_clear();
        compare_all();
        chk("t4_taps_async", taps, 32'h0);
        res = 1'b0;
        take_one(8'h0A); take_one(8'h0B); take_one(8'h0C); take_one(8'h0D);
        idle();
`ifdef FORCE_MAX_TAP_EN
        chk("t4_taps", taps, 32'h0D0C0B1F);
`else
        chk("t4_taps", taps, 32'h0D0C0B0A);
`endif
        restart();

        // clr beats take on the same edge
        take_one(8'h01); take_one(8'h02); take_one(8'h03);
        step(1'b1, 1'b1, 1'b1, 8'h0A);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_taps", taps, 32'h0);
        chk("t5_rej", 32'(rejected), 32'd0);

        // ena low in FINISH freezes the step to DONE
        take_one(8'h1F); take_one(8'h11); take_one(8'h12); take_one(8'h13);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'(i % 2 == 0), 8'h14);
        chk("t6_done_frozen", 32'(done), 32'd0);
        chk("t6_taps_frozen", taps, 32'h1312111F);
        idle();
        chk("t6_done", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
